// File: rtl/sb_pkg.sv
// Shared constants and the per-entry update op for the RAW scoreboard.
package sb_pkg;
    localparam int NREG  = 32;
    localparam int IDX_W = 5;
    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        INC  = 2'd1,
        DEC  = 2'd2,
        CLR  = 2'd3
    } sb_op_e;
endpackage

// File: rtl/sb_entry.sv
// One pending-write counter; the top resolves inc/dec/flush into a single op.
module sb_entry
    import sb_pkg::*;
(
    input  logic             core_clk,
    input  logic             core_rst,
    input  sb_op_e           op,
    output logic [CNT_W-1:0] cnt,
    output logic             busy
);
    always_ff @(posedge core_clk or negedge core_rst) begin
        if (!core_rst) begin
            cnt <= '0;
        end else begin
            case (op)
                INC:     cnt <= cnt + CNT_W'(1);
                DEC:     cnt <= cnt - CNT_W'(1);
                CLR:     cnt <= '0;
                default: cnt <= cnt;
            endcase
        end
    end

    assign busy = |cnt;
endmodule

// File: rtl/raw_scoreboard.sv
// Register scoreboard: holds issue while a source, or a saturated destination,
// has in-flight writes. Counters set at issue, retired at writeback.
module raw_scoreboard
    import sb_pkg::*;
#(
    parameter int PERF_W = 32
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              issue_valid,
    input  logic              issue_src1_en,
    input  logic [IDX_W-1:0]  issue_src1,
    input  logic              issue_src2_en,
    input  logic [IDX_W-1:0]  issue_src2,
    input  logic              issue_dst_en,
    input  logic [IDX_W-1:0]  issue_dst,
    output logic              issue_ready,
    input  logic              wb_valid,
    input  logic [IDX_W-1:0]  wb_dst,
    input  logic              flush,
    output logic [NREG-1:0]   busy_vec,
    output logic              idle,
    output logic [PERF_W-1:0] stall_cnt,
    output logic              err
);
    logic [NREG-1:0][CNT_W-1:0] cnt;
    logic [NREG-1:0]            busy;
    logic [NREG-1:0]            inc_oh, wb_oh;
    logic                       haz_src1, haz_src2, haz_dst, fire, wb_spurious;

    // Hazards look only at registered counts; a same-cycle writeback does not unblock.
    assign haz_src1    = issue_src1_en && (issue_src1 != '0) && (cnt[issue_src1] != '0);
    assign haz_src2    = issue_src2_en && (issue_src2 != '0) && (cnt[issue_src2] != '0);
    assign haz_dst     = issue_dst_en  && (issue_dst  != '0) && (cnt[issue_dst] == CNT_MAX);
    assign issue_ready = !flush && !(haz_src1 || haz_src2 || haz_dst);
    assign fire        = issue_valid && issue_ready;

    assign inc_oh = (fire && issue_dst_en) ? (NREG'(1) << issue_dst) : '0;
    assign wb_oh  = wb_valid ? (NREG'(1) << wb_dst) : '0;

    assign cnt[0]  = '0;
    assign busy[0] = 1'b0;

    for (genvar r = 1; r < NREG; r++) begin : g_ent
        sb_op_e op;
        logic   inc, dec;

        assign inc = inc_oh[r];
        assign dec = wb_oh[r] && (cnt[r] != '0);

        always_comb begin
            op = HOLD;
            if (flush)           op = CLR;
            else if (inc && !dec) op = INC;
            else if (dec && !inc) op = DEC;
        end

        sb_entry u_ent (
            .core_clk (core_clk),
            .core_rst (core_rst),
            .op       (op),
            .cnt      (cnt[r]),
            .busy     (busy[r])
        );
    end

    // Counters are registered, so these already reflect the post-edge state.
    assign busy_vec = busy;
    assign idle     = ~|busy;

    assign wb_spurious = wb_valid && !flush && (wb_dst != '0) && (cnt[wb_dst] == '0);

    always_ff @(posedge core_clk or negedge core_rst) begin
        if (!core_rst) begin
            stall_cnt <= '0;
            err       <= 1'b0;
        end else begin
            if (issue_valid && !issue_ready && !flush && (stall_cnt != '1))
                stall_cnt <= stall_cnt + PERF_W'(1);
            if (wb_spurious)
                err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_raw_scoreboard.sv
// Directed bench for raw_scoreboard with hand-computed expectations.
module tb_raw_scoreboard;
    import sb_pkg::*;

    logic              core_clk = 1'b0;
    logic              core_rst = 1'b0;
    logic              issue_valid = 1'b0;
    logic              issue_src1_en = 1'b0;
    logic [IDX_W-1:0]  issue_src1 = '0;
    logic              issue_src2_en = 1'b0;
    logic [IDX_W-1:0]  issue_src2 = '0;
    logic              issue_dst_en = 1'b0;
    logic [IDX_W-1:0]  issue_dst = '0;
    logic              issue_ready;
    logic              wb_valid = 1'b0;
    logic [IDX_W-1:0]  wb_dst = '0;
    logic              flush = 1'b0;
    logic [NREG-1:0]   busy_vec;
    logic              idle;
    logic [31:0]       stall_cnt;
    logic              err;

    int n_chk = 0;
    int n_pass = 0;

    raw_scoreboard #(.PERF_W(32)) dut (
        .core_clk      (core_clk),
        .core_rst      (core_rst),
        .issue_valid   (issue_valid),
        .issue_src1_en (issue_src1_en),
        .issue_src1    (issue_src1),
        .issue_src2_en (issue_src2_en),
        .issue_src2    (issue_src2),
        .issue_dst_en  (issue_dst_en),
        .issue_dst     (issue_dst),
        .issue_ready   (issue_ready),
        .wb_valid      (wb_valid),
        .wb_dst        (wb_dst),
        .flush         (flush),
        .busy_vec      (busy_vec),
        .idle          (idle),
        .stall_cnt     (stall_cnt),
        .err           (err)
    );

    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge core_clk);
        #1;
    endtask

    task automatic idle_in();
        issue_valid = 0; issue_src1_en = 0; issue_src1 = '0; issue_src2_en = 0; issue_src2 = '0;
        issue_dst_en = 0; issue_dst = '0; wb_valid = 0; wb_dst = '0; flush = 0;
    endtask

    // One-cycle issue writing rd, no sources.
    task automatic issue_wr(input int rd);
        idle_in();
        issue_valid = 1; issue_dst_en = 1; issue_dst = IDX_W'(rd);
        step();
        idle_in();
    endtask

    task automatic wb(input int rd);
        idle_in();
        wb_valid = 1; wb_dst = IDX_W'(rd);
        step();
        idle_in();
    endtask

    initial begin
        idle_in();
        #12;
        chk("rst_busy", busy_vec, 32'h0);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_stall", stall_cnt, 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        core_rst = 1;
        step();
        chk("rst_ready", 32'(issue_ready), 32'd1);

        // Basic RAW on x5
        issue_wr(5);
        chk("b5_busy", busy_vec, 32'h20);
        chk("b5_idle", 32'(idle), 32'd0);
        issue_valid = 1; issue_src1_en = 1; issue_src1 = 5'd5;
        #1 chk("raw_ready", 32'(issue_ready), 32'd0);
        step(); step(); step();
        chk("raw_stall3", stall_cnt, 32'd3);
        wb_valid = 1; wb_dst = 5'd5;
        #1 chk("wb_no_bypass", 32'(issue_ready), 32'd0);
        step();
        wb_valid = 0;
        chk("wb_ready", 32'(issue_ready), 32'd1);
        chk("wb_busy", busy_vec, 32'h0);
        chk("wb_idle", 32'(idle), 32'd1);
        chk("wb_stall4", stall_cnt, 32'd4);
        step();
        idle_in();

        // Same-cycle issue and writeback on x7
        issue_wr(7);
        idle_in();
        issue_valid = 1; issue_dst_en = 1; issue_dst = 5'd7; wb_valid = 1; wb_dst = 5'd7;
        step();
        idle_in();
        chk("same_busy7", busy_vec, 32'h80);
        wb(7);
        chk("same_clear7", busy_vec, 32'h0);

        // Saturation on x3
        issue_wr(3); issue_wr(3); issue_wr(3);
        issue_valid = 1; issue_dst_en = 1; issue_dst = 5'd3;
        #1 chk("sat_ready", 32'(issue_ready), 32'd0);
        step();
        wb_valid = 1; wb_dst = 5'd3;
        step();
        wb_valid = 0;
        chk("sat_wb_ready", 32'(issue_ready), 32'd1);
        chk("sat_stall6", stall_cnt, 32'd6);
        step();
        idle_in();
        wb(3); wb(3);
        chk("sat_busy", busy_vec, 32'h8);
        wb(3);
        chk("sat_idle", 32'(idle), 32'd1);
        chk("sat_err", 32'(err), 32'd0);

        // x0 is never tracked
        issue_valid = 1; issue_src1_en = 1; issue_src1 = 5'd0; issue_dst_en = 1; issue_dst = 5'd0;
        #1 chk("x0_ready", 32'(issue_ready), 32'd1);
        step();
        idle_in();
        chk("x0_busy", busy_vec, 32'h0);
        wb(0);
        chk("x0_err", 32'(err), 32'd0);

        // Flush with pending 2,4,9 and simultaneous issue/wb
        issue_wr(2); issue_wr(4); issue_wr(9);
        chk("fl_pre_busy", busy_vec, 32'h214);
        flush = 1; issue_valid = 1; issue_dst_en = 1; issue_dst = 5'd5; wb_valid = 1; wb_dst = 5'd2;
        #1 chk("fl_ready", 32'(issue_ready), 32'd0);
        step();
        idle_in();
        chk("fl_busy", busy_vec, 32'h0);
        chk("fl_idle", 32'(idle), 32'd1);
        chk("fl_err", 32'(err), 32'd0);
        chk("fl_stall", stall_cnt, 32'd6);

        // Spurious writeback sets sticky err
        wb(6);
        chk("sp_err", 32'(err), 32'd1);
        step();
        chk("sp_err_sticky", 32'(err), 32'd1);

        // Asynchronous reset mid-stall
        issue_wr(5);
        issue_valid = 1; issue_src1_en = 1; issue_src1 = 5'd5;
        step(); step();
        chk("mr_stall", stall_cnt, 32'd8);
        #2 core_rst = 0;
        #1;
        chk("mr_err", 32'(err), 32'd0);
        chk("mr_stall0", stall_cnt, 32'd0);
        chk("mr_busy", busy_vec, 32'h0);
        chk("mr_ready", 32'(issue_ready), 32'd1);
        idle_in();
        step();
        core_rst = 1;
        step();
        chk("mr_idle", 32'(idle), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
